// File: rtl/rst_seq_ctrl_if.sv
// Request/status bundle between a reset sequencer and its consumers.
// Requests are one-cycle pulses; outputs are registered reset lines.
interface rst_seq_ctrl_if #(
    parameter int N_DOM = 4
);
    logic             sw_rst_req;
    logic             wdt_rst_req;
    logic [N_DOM-1:0] dom_rst_n;
    logic             rst_busy;
    logic [1:0]       rst_cause;

    modport master (
        output sw_rst_req,
        output wdt_rst_req,
        input  dom_rst_n,
        input  rst_busy,
        input  rst_cause
    );

    modport slave (
        input  sw_rst_req,
        input  wdt_rst_req,
        output dom_rst_n,
        output rst_busy,
        output rst_cause
    );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Ordered reset release: hold all domains, then release them one by one
// at fixed spacing; software/watchdog requests restart the sequence.
module rst_seq_ctrl #(
    parameter int N_DOM = 4,
    parameter int HOLD  = 8,
    parameter int STEP  = 4
) (
    input  logic          clk,
    input  logic          rst_async_n,
    rst_seq_ctrl_if.slave bus
);

    localparam int IW = (N_DOM > 1) ? $clog2(N_DOM) : 1;
    localparam logic [7:0]    HOLD_C = 8'(HOLD);
    localparam logic [7:0]    STEP_C = 8'(STEP);
    localparam logic [IW-1:0] LAST   = IW'(N_DOM - 1);
    localparam logic [1:0]    C_POR  = 2'b00;
    localparam logic [1:0]    C_SW   = 2'b01;
    localparam logic [1:0]    C_WDT  = 2'b10;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        IDLE    = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [N_DOM-1:0] dom_q, dom_d;
    logic             busy_q, busy_d;
    logic [1:0]       cause_q, cause_d;
    logic             arm_q, arm_d;
    logic [7:0]       cnt_inc;
    logic             restart;

    // Power-on leaves arm_q clear so the first edge after reset release
    // acts as edge 0, matching the edge on which a request enters ASSERT.
    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            state_q <= ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            dom_q   <= '0;
            busy_q  <= 1'b1;
            cause_q <= C_POR;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dom_q   <= dom_d;
            busy_q  <= busy_d;
            cause_q <= cause_d;
            arm_q   <= arm_d;
        end
    end

    assign cnt_inc = cnt_q + 8'd1;
    assign restart = bus.wdt_rst_req
                   | (bus.sw_rst_req & (state_q == IDLE));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dom_d   = dom_q;
        busy_d  = busy_q;
        cause_d = cause_q;
        arm_d   = arm_q;

        unique case (state_q)
            ASSERT: begin
                if (!arm_q) begin
                    arm_d = 1'b1;
                end else if (cnt_inc == HOLD_C) begin
                    dom_d[0] = 1'b1;
                    cnt_d    = '0;
                    if (N_DOM == 1) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = RELEASE;
                        idx_d   = IW'(1);
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RELEASE: begin
                if (cnt_inc == STEP_C) begin
                    for (int k = 0; k < N_DOM; k++) begin
                        if (idx_q == IW'(k)) dom_d[k] = 1'b1;
                    end
                    cnt_d = '0;
                    idx_d = idx_q + IW'(1);
                    if (idx_q == LAST) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            IDLE: begin
            end
            default: begin
                state_d = ASSERT;
            end
        endcase

        if (restart) begin
            state_d = ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            dom_d   = '0;
            busy_d  = 1'b1;
            arm_d   = 1'b1;
            cause_d = bus.wdt_rst_req ? C_WDT : C_SW;
        end
    end

    assign bus.dom_rst_n = dom_q;
    assign bus.rst_busy  = busy_q;
    assign bus.rst_cause = cause_q;

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
- REQ-001: Parameter N_DOM, default 4, is the number of reset domains released in order, from domain 0 up to N_DOM-1 (legal range 1..8).
- REQ-002: Parameter HOLD, default 8, is the cycles all domains stay asserted before domain 0 is released (legal range 1..255).
- REQ-003: Parameter STEP, default 4, is the cycles between consecutive domain releases (legal range 1..255).
- REQ-004: clk  input  1  is the single clock; all state is on its rising edge.
- REQ-005: rst_async_n  input  1  is the asynchronous, active-low reset; its deassertion is already synchronized to clk upstream.
- REQ-006: sw_rst_req  input  1  is a software reset request, a one-cycle pulse synchronous to clk.
- REQ-007: wdt_rst_req  input  1  is a watchdog reset request, a one-cycle pulse synchronous to clk.
- REQ-008: dom_rst_n  output  N_DOM  gives the per-domain active-low resets; every bit is registered.
- REQ-009: rst_busy  output  1  is high while any domain is still held in reset; it is registered.
- REQ-010: rst_cause  output  2  records the last reset cause (00 = power-on/async, 01 = software, 10 = watchdog, 11 = unused); it is registered.

Function
- REQ-011: The FSM has three states: ASSERT, RELEASE and IDLE; an 8-bit cycle counter cnt and a domain index idx are also kept.
- REQ-012: In ASSERT, all dom_rst_n bits are 0, rst_busy is 1, and cnt increments each edge.
- REQ-013: ASSERT ends on the edge where cnt reaches HOLD; on that edge dom_rst_n[0] goes to 1, idx goes to 1, cnt clears and the FSM enters RELEASE.
- REQ-014: In RELEASE, cnt increments each edge; on the edge where cnt reaches STEP, dom_rst_n[idx] goes to 1, idx increments and cnt clears.
- REQ-015: Timing is measured with edge 0 as the edge on which ASSERT is entered (for power-on, edge 0 is reset release); dom_rst_n[k] rises on edge HOLD + k*STEP.
- REQ-016: The edge that releases domain N_DOM-1 also enters IDLE and drives rst_busy to 0.
- REQ-017: If N_DOM = 1, the FSM goes directly from ASSERT to IDLE at edge HOLD.
- REQ-018: Released domains stay released; dom_rst_n bits are monotonic 0 to 1 within one sequence.
- REQ-019: In IDLE, a request sampled high on edge T takes effect on that edge: all dom_rst_n bits go to 0, rst_busy goes to 1, cnt clears, the FSM enters ASSERT and rst_cause is updated.
- REQ-020: The new sequence started by REQ-019 is timed per REQ-015 with edge 0 = T.
- REQ-021: If sw_rst_req and wdt_rst_req are high on the same edge, watchdog wins and rst_cause is set to 10.
- REQ-022: wdt_rst_req in ASSERT or RELEASE restarts the sequence: all domains go to 0, cnt and idx clear, the FSM enters ASSERT, and rst_cause is set to 10.
- REQ-023: sw_rst_req in ASSERT or RELEASE is ignored, with no effect on any state or output.
- REQ-024: Requests are edge-sampled only; a request held high for several cycles in IDLE triggers exactly one sequence on the first edge, and REQ-023 governs any cycles after that.
- REQ-025: Counter comparisons use equality against the parameter values zero-extended to 8 bits; cnt never wraps.

Reset
- REQ-026: rst_async_n low forces, asynchronously: dom_rst_n = all 0, rst_busy = 1, rst_cause = 00, FSM = ASSERT, cnt = 0, idx = 0.
- REQ-027: Assertion of rst_async_n mid-sequence or in IDLE aborts everything immediately, and rst_cause returns to 00.
- REQ-028: A new sequence starts from edge 0 at the first rising edge after rst_async_n deasserts.
- REQ-029: No output glitches high while rst_async_n is low.

Verification
- REQ-030: Power-on check, defaults (N_DOM = 4, HOLD = 8, STEP = 4) -> dom_rst_n bits rise at edges 8, 12, 16, 20; rst_busy falls at edge 20; rst_cause = 00.
- REQ-031: IDLE, sw_rst_req pulsed at edge 30 -> dom_rst_n = 0000 after edge 30; bits rise at edges 38, 42, 46, 50; rst_cause = 01.
- REQ-032: Watchdog mid-sequence: wdt_rst_req at edge 14 during power-on sequence -> dom_rst_n = 0000 after edge 14; releases at edges 22, 26, 30, 34; rst_cause = 10.
- REQ-033: Software request mid-sequence: sw_rst_req at edge 10 -> no change; power-on timing per REQ-030 exactly; rst_cause stays 00.
- REQ-034: Simultaneous requests: sw_rst_req and wdt_rst_req both high at edge 40 in IDLE -> one sequence only, rst_cause = 10.
- REQ-035: Async abort and corner configs: rst_async_n low between edges 17 and 18 -> outputs reset immediately without waiting for a clock; after release, the full power-on sequence repeats; N_DOM = 1 and HOLD = STEP = 1 corner configurations are also run.
